fpu_dot_seq: RTL

FPU_DOT_SEQ -- requirements
Module: fpu_dot_seq

---
 rtl/data_type_pkg.sv | 25 ++
 rtl/fpu_dot_fsm.sv | 42 ++++
 rtl/fpu_dot_seq.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/data_type_pkg.sv
// Shared types and constants for the bfloat16 dot-product sequencer.
package data_type_pkg;

  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned MODE_WIDTH = 2;

  localparam logic [MODE_WIDTH-1:0] MODE_ADD = 2'd0;
  localparam logic [MODE_WIDTH-1:0] MODE_MUL = 2'd1;

  localparam logic [DATA_WIDTH-1:0] BF16_ZERO = 16'h0000;

  typedef enum logic [2:0] {
    StIdle,
    StWaitOp,
    StMul,
    StAdd,
    StDone
  } dot_state_e;

  // Matches +0 and -0: exponent and fraction both clear.
  function automatic logic is_bf16_zero(input logic [DATA_WIDTH-1:0] x);
    return x[DATA_WIDTH-2:0] == '0;
  endfunction

endpackage

// File: rtl/fpu_dot_fsm.sv
// Control FSM for fpu_dot_seq: state register plus next-state logic.
module fpu_dot_fsm
  import data_type_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       len_zero_i,
  input  logic       a_fire_i,
  input  logic       skip_i,
  input  logic       last_i,
  input  logic       res_ready_i,
  output dot_state_e state_o
);

  dot_state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start_i) state_d = len_zero_i ? StDone : StWaitOp;
      StWaitOp: begin
        if (a_fire_i) begin
          if (skip_i) state_d = last_i ? StDone : StWaitOp;
          else        state_d = StMul;
        end
      end
      StMul:    state_d = StAdd;
      StAdd:    state_d = last_i ? StDone : StWaitOp;
      StDone:   if (res_ready_i) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= StIdle;
    else       state_q <= state_d;
  end

  assign state_o = state_q;

endmodule

// File: rtl/fpu_dot_seq.sv
// Sequences a bfloat16 dot product over a shared external combinational FPU.
// Optional FPU_DOT_ZERO_SKIP_EN: pairs with a +/-0 operand bypass MUL/ADD.
module fpu_dot_seq
  import data_type_pkg::*;
#(
  parameter int unsigned VEC_LEN = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic [$clog2(VEC_LEN+1)-1:0] len_i,
  input  logic                         a_valid_i,
  output logic                         a_ready_o,
  input  logic [DATA_WIDTH-1:0]        a_i,
  input  logic [DATA_WIDTH-1:0]        b_i,
  output logic [MODE_WIDTH-1:0]        fpu_mode_o,
  output logic [DATA_WIDTH-1:0]        fpu_in1_o,
  output logic [DATA_WIDTH-1:0]        fpu_in2_o,
  input  logic [DATA_WIDTH-1:0]        fpu_out_i,
  input  logic                         fpu_ovf_i,
  output logic                         res_valid_o,
  input  logic                         res_ready_i,
  output logic [DATA_WIDTH-1:0]        res_o,
  output logic                         res_ovf_o,
  output logic                         busy_o
);

  localparam int unsigned CntW = $clog2(VEC_LEN + 1);
  localparam logic [CntW-1:0] MaxLen = CntW'(VEC_LEN);

  dot_state_e state;

  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, prod_q, prod_d, acc_q, acc_d;
  logic [CntW-1:0]       cnt_q, cnt_d, len_q, len_d;
  logic                  ovf_q, ovf_d;

  logic            a_fire, skip, last;
  logic [CntW-1:0] cnt_inc, len_clamp;

  assign a_fire    = (state == StWaitOp) && a_valid_i;
  assign cnt_inc   = cnt_q + CntW'(1);
  assign last      = (cnt_inc == len_q);
  assign len_clamp = (len_i > MaxLen) ? MaxLen : len_i;

`ifdef FPU_DOT_ZERO_SKIP_EN
  assign skip = is_bf16_zero(a_i) || is_bf16_zero(b_i);
`else
  assign skip = 1'b0;
`endif

  fpu_dot_fsm u_fsm (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .len_zero_i  (len_i == '0),
    .a_fire_i    (a_fire),
    .skip_i      (skip),
    .last_i      (last),
    .res_ready_i (res_ready_i),
    .state_o     (state)
  );

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    prod_d = prod_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    len_d  = len_q;
    ovf_d  = ovf_q;
    case (state)
      StIdle: begin
        if (start_i) begin
          acc_d = BF16_ZERO;
          cnt_d = '0;
          ovf_d = 1'b0;
          len_d = len_clamp;
        end
      end
      StWaitOp: begin
        if (a_fire) begin
          a_d = a_i;
          b_d = b_i;
          if (skip) cnt_d = cnt_inc;
        end
      end
      StMul: begin
        prod_d = fpu_out_i;
        ovf_d  = ovf_q | fpu_ovf_i;
      end
      StAdd: begin
        acc_d = fpu_out_i;
        ovf_d = ovf_q | fpu_ovf_i;
        cnt_d = cnt_inc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q    <= BF16_ZERO;
      b_q    <= BF16_ZERO;
      prod_q <= BF16_ZERO;
      acc_q  <= BF16_ZERO;
      cnt_q  <= '0;
      len_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      prod_q <= prod_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      len_q  <= len_d;
      ovf_q  <= ovf_d;
    end
  end

  // FPU operands are parked at zero/ADD whenever the FPU is not in use.
  always_comb begin
    fpu_mode_o = MODE_ADD;
    fpu_in1_o  = BF16_ZERO;
    fpu_in2_o  = BF16_ZERO;
    if (state == StMul) begin
      fpu_mode_o = MODE_MUL;
      fpu_in1_o  = a_q;
      fpu_in2_o  = b_q;
    end else if (state == StAdd) begin
      fpu_in1_o = acc_q;
      fpu_in2_o = prod_q;
    end
  end

  assign a_ready_o   = (state == StWaitOp);
  assign res_valid_o = (state == StDone);
  assign res_o       = res_valid_o ? acc_q : BF16_ZERO;
  assign res_ovf_o   = res_valid_o & ovf_q;
  assign busy_o      = (state != StIdle);

endmodule
